uart_rx_data_sampler: RTL and testbench
=======================================

Name: uart_rx_data_sampler

Overview:
- Sits directly downstream of the UART-RX edge/bit counter.
- Synchronises RX_IN into the oversampling clock domain and takes three samples around the middle of each bit, using edge_count from the counter.
- Produces one majority-voted bit per bit period.
- When enabled by the RX FSM, shifts those bits LSB-first into a parallel data register and flags byte completion for the parity/stop check stages.

Parameters:
- PRESCALE, 8, oversampling edges per bit; legal values 4, 8, 16.
- EDGE_W, 4, width of edge_count; must satisfy 2^EDGE_W >= PRESCALE.
- DATA_W, 8, data bits per frame; legal range 5..8.

Ports:
- clk_based_on_prescale  input  1  oversampling clock, PRESCALE edges per bit.
- asy_reset  input  1  asynchronous, active-high reset.
- RX_IN  input  1  raw serial line; idle high; asynchronous to the clock.
- edge_count  input  EDGE_W  edge index within the current bit, from the edge/bit counter; runs 0..PRESCALE-1.
- sample_en  input  1  from the RX FSM; sampling allowed while high.
- deser_en  input  1  from the RX FSM; high during the data-bit states.
- deser_clr  input  1  from the RX FSM; synchronous clear of the shift count, pulsed in the start state.
- rx_sync  output  1  synchronised RX_IN, for the start-edge detector.
- sampled_bit  output  1  majority-voted bit value.
- sample_valid  output  1  one-cycle strobe: sampled_bit is updated.
- P_DATA  output  DATA_W  deserialised data, LSB received first.
- byte_done  output  1  one-cycle strobe: DATA_W bits have been shifted.

Behaviour:
- Reset (asy_reset=1, asynchronous):
  - synchroniser FFs = 1, so rx_sync=1;
  - s0=s1=1, sampled_bit=1, sample_valid=0;
  - P_DATA=0, shift count=0, byte_done=0.
- Synchroniser:
  - two-flop chain; rx_sync = second flop.
  - Latency from RX_IN to rx_sync: 2 clocks. The FSM and counter already account for this; there is no compensation inside this block.
- Sample points, with M = PRESCALE/2:
  - edges M-1, M, M+1; for PRESCALE=8 these are 3, 4, 5.
  - at edge_count==M-1 with sample_en: s0 <= rx_sync.
  - at edge_count==M with sample_en: s1 <= rx_sync.
  - at edge_count==M+1 with sample_en: sampled_bit <= majority(s0, s1, rx_sync) and sample_valid <= 1 on the next clock.
  - sample_valid is otherwise 0. There is exactly one strobe per bit period.
- sample_en low:
  - s0/s1 hold their values; no strobe is issued.
  - If sample_en drops between edge M-1 and edge M+1, no strobe is issued for that bit. The stale s0/s1 are overwritten on the next bit.
- Out-of-range edge_count (>= PRESCALE): no effect.
- Deserialiser:
  - on a clock where sample_valid=1 and deser_en=1: P_DATA <= {sampled_bit, P_DATA[DATA_W-1:1]} and count <= count+1.
  - when the count reaches DATA_W on that shift: byte_done=1 on the following clock and count <= 0.
  - P_DATA holds until the next shift; it is not cleared by byte_done.
- deser_clr: count <= 0 synchronously; P_DATA is not cleared. deser_clr has priority over a simultaneous shift: the count clears and the shift is dropped.
- deser_en low: no shifts, so start, parity and stop bits never enter P_DATA.
- Count wrap: the count never exceeds DATA_W. Further shifts after byte_done start a new byte.
- Reset mid-frame: all state returns to the reset values immediately, with no partial strobe.

Decomposition:
- Shared package uart_rx_pkg holds:
  - PRESCALE_DEF, DATA_W_DEF;
  - a function mid_edge(prescale) returning M;
  - a 3-input majority function, reused by the start-bit glitch filter.
- One natural sub-module, uart_rx_deserializer, containing the shift register, count and byte_done. The sampler logic and synchroniser stay in the top level.

Test Plan:
- Reset: assert asy_reset mid-run -> rx_sync=1, sampled_bit=1, sample_valid=0, P_DATA=0x00 and byte_done=0 in the same cycle, without waiting for a clock.
- Clean frame, PRESCALE=8: send 0x A5 LSB-first with sample_en=1 and deser_en=1 over the 8 data bits -> 8 sample_valid strobes, each 1 clock after edge_count=5; byte_done 1 clock after the 8th; P_DATA=0xA5.
- Glitch rejection: bit=1 with RX_IN forced low only at the edge-4 sample -> sampled_bit=1. With RX_IN low at both the edge-3 and edge-4 samples -> sampled_bit=0.
- Gating:
  - deser_en=0 during the start bit (0) and stop bit (1) -> sample_valid still pulses, P_DATA and the count are unchanged.
  - sample_en=0 for a whole bit -> no strobe.
- Clear priority: deser_clr=1 coincident with sample_valid after 3 shifts -> count=0, P_DATA unchanged. The next 8 shifts of 0x3C give byte_done with P_DATA=0x3C.
- PRESCALE=16: sample points 7, 8, 9; frame 0x5A -> P_DATA=0x5A and one strobe per 16 clocks.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: default geometry,
// the mid-bit sample edge helper and the 3-input majority voter.
package uart_rx_pkg;

    localparam int PRESCALE_DEF = 8;
    localparam int DATA_W_DEF   = 8;

    // Middle edge of a bit period; the three samples sit at M-1, M, M+1.
    function automatic int mid_edge(input int prescale);
        return prescale / 32'sd2;
    endfunction

    // 2-of-3 vote; also used by the start-bit glitch filter.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer.sv
// LSB-first shift register with a bit count and a one-cycle byte_done
// strobe. A synchronous clear resets the count and wins over a shift.
module uart_rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift_valid,
    input  logic              i_shift_bit,
    input  logic              i_deser_en,
    input  logic              i_deser_clr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_byte_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data;
    logic              r_byte_done;
    logic              w_shift;
    logic              w_last;

    // Decide whether this clock shifts, and whether that shift ends the byte.
    always_comb begin
        w_shift = 1'b0;
        w_last  = 1'b0;
        if (i_shift_valid && i_deser_en && !i_deser_clr) begin
            w_shift = 1'b1;
            w_last  = (r_count == CNT_LAST);
        end else begin
            w_shift = 1'b0;
            w_last  = 1'b0;
        end
    end

    // Shift register, bit count and completion strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count     <= {CNT_W{1'b0}};
            r_data      <= {DATA_W{1'b0}};
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= w_last;
            if (i_deser_clr) begin
                r_count <= {CNT_W{1'b0}};
            end else if (w_last) begin
                r_count <= {CNT_W{1'b0}};
            end else if (w_shift) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_shift) begin
                r_data <= {i_shift_bit, r_data[DATA_W-1:1]};
            end
        end
    end

    assign o_data      = r_data;
    assign o_byte_done = r_byte_done;

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX data sampler: two-flop synchroniser, three mid-bit samples with
// a majority vote, and the LSB-first deserialiser behind it.
module uart_rx_data_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int EDGE_W   = 4,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk_based_on_prescale,
    input  logic              asy_reset,
    input  logic              RX_IN,
    input  logic [EDGE_W-1:0] edge_count,
    input  logic              sample_en,
    input  logic              deser_en,
    input  logic              deser_clr,
    output logic              rx_sync,
    output logic              sampled_bit,
    output logic              sample_valid,
    output logic [DATA_W-1:0] P_DATA,
    output logic              byte_done
);

    localparam int MID = mid_edge(PRESCALE);
    localparam logic [EDGE_W-1:0] EDGE_S0   = EDGE_W'(MID - 32'sd1);
    localparam logic [EDGE_W-1:0] EDGE_S1   = EDGE_W'(MID);
    localparam logic [EDGE_W-1:0] EDGE_VOTE = EDGE_W'(MID + 32'sd1);

    logic [1:0] r_sync;
    logic       r_s0;
    logic       r_s1;
    logic       r_armed;
    logic       r_sampled_bit;
    logic       r_sample_valid;
    logic       w_at_s0;
    logic       w_at_s1;
    logic       w_at_vote;
    logic       w_vote;
    logic       w_armed_nxt;

    // Sample-point decode. r_armed tracks an unbroken run of sample_en
    // from the first sample, so a drop mid-window suppresses the strobe.
    always_comb begin
        w_at_s0     = sample_en && (edge_count == EDGE_S0);
        w_at_s1     = sample_en && (edge_count == EDGE_S1);
        w_at_vote   = sample_en && (edge_count == EDGE_VOTE);
        w_vote      = w_at_vote && r_armed;
        w_armed_nxt = r_armed;
        if (!sample_en) begin
            w_armed_nxt = 1'b0;
        end else if (w_at_s0) begin
            w_armed_nxt = 1'b1;
        end else if (w_at_vote) begin
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = r_armed;
        end
    end

    // Two-flop synchroniser; idles high like the line itself.
    always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
        if (asy_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    // Capture the two early samples and vote on the third.
    always_ff @(posedge clk_based_on_prescale or posedge asy_reset) begin
        if (asy_reset) begin
            r_s0           <= 1'b1;
            r_s1           <= 1'b1;
            r_armed        <= 1'b0;
            r_sampled_bit  <= 1'b1;
            r_sample_valid <= 1'b0;
        end else begin
            r_armed        <= w_armed_nxt;
            r_sample_valid <= w_vote;
            if (w_at_s0) begin
                r_s0 <= r_sync[1];
            end
            if (w_at_s1) begin
                r_s1 <= r_sync[1];
            end
            if (w_vote) begin
                r_sampled_bit <= majority3(r_s0, r_s1, r_sync[1]);
            end
        end
    end

    uart_rx_deserializer #(
        .DATA_W(DATA_W)
    ) u_deser (
        .i_clk         (clk_based_on_prescale),
        .i_rst         (asy_reset),
        .i_shift_valid (r_sample_valid),
        .i_shift_bit   (r_sampled_bit),
        .i_deser_en    (deser_en),
        .i_deser_clr   (deser_clr),
        .o_data        (P_DATA),
        .o_byte_done   (byte_done)
    );

    assign rx_sync      = r_sync[1];
    assign sampled_bit  = r_sampled_bit;
    assign sample_valid = r_sample_valid;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Scoreboard bench: stimulus pushes expected sampled bits and bytes,
// a forked monitor pops and compares on every strobe.
module tb_uart_rx_data_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: PRESCALE=8
    logic       rst_a, rx_a, se_a, de_a, dc_a;
    logic [3:0] ec_a;
    logic       sync_a, sb_a, sv_a, bd_a;
    logic [7:0] pd_a;
    // Instance B: PRESCALE=16
    logic       rst_b, rx_b, se_b, de_b, dc_b;
    logic [3:0] ec_b;
    logic       sync_b, sb_b, sv_b, bd_b;
    logic [7:0] pd_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_strobe_b = -1;

    logic       exp_bit_a[$];
    logic       exp_bit_b[$];
    logic [7:0] exp_byte_a[$];
    logic [7:0] exp_byte_b[$];

    uart_rx_data_sampler #(.PRESCALE(8), .EDGE_W(4), .DATA_W(8)) dut_a (
        .clk_based_on_prescale(clk), .asy_reset(rst_a), .RX_IN(rx_a),
        .edge_count(ec_a), .sample_en(se_a), .deser_en(de_a), .deser_clr(dc_a),
        .rx_sync(sync_a), .sampled_bit(sb_a), .sample_valid(sv_a),
        .P_DATA(pd_a), .byte_done(bd_a)
    );

    uart_rx_data_sampler #(.PRESCALE(16), .EDGE_W(4), .DATA_W(8)) dut_b (
        .clk_based_on_prescale(clk), .asy_reset(rst_b), .RX_IN(rx_b),
        .edge_count(ec_b), .sample_en(se_b), .deser_en(de_b), .deser_clr(dc_b),
        .rx_sync(sync_b), .sampled_bit(sb_b), .sample_valid(sv_b),
        .P_DATA(pd_b), .byte_done(bd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sv_a === 1'b1) begin
                check("strobe_edge_a", 32'(ec_a), 32'd5);
                check("strobe_expected_a", 32'(exp_bit_a.size() > 0), 32'd1);
                if (exp_bit_a.size() > 0) check("sampled_bit_a", 32'(sb_a), 32'(exp_bit_a.pop_front()));
            end
            if (bd_a === 1'b1) begin
                check("byte_expected_a", 32'(exp_byte_a.size() > 0), 32'd1);
                if (exp_byte_a.size() > 0) check("p_data_a", 32'(pd_a), 32'(exp_byte_a.pop_front()));
            end
            if (sv_b === 1'b1) begin
                check("strobe_edge_b", 32'(ec_b), 32'd9);
                if (last_strobe_b >= 0) check("strobe_interval_b", 32'(cyc - last_strobe_b), 32'd16);
                last_strobe_b = cyc;
                check("strobe_expected_b", 32'(exp_bit_b.size() > 0), 32'd1);
                if (exp_bit_b.size() > 0) check("sampled_bit_b", 32'(sb_b), 32'(exp_bit_b.pop_front()));
            end
            if (bd_b === 1'b1) begin
                check("byte_expected_b", 32'(exp_byte_b.size() > 0), 32'd1);
                if (exp_byte_b.size() > 0) check("p_data_b", 32'(pd_b), 32'(exp_byte_b.pop_front()));
            end
        end
    endtask

    // One bit period. low_mask[k] forces the line low so that the sample
    // taken at edge k sees 0 (the synchroniser delays RX_IN by 2 clocks).
    task automatic send_bit(input bit inst_b, input logic bitval, input logic [15:0] en_mask,
                            input logic [15:0] low_mask, input logic de, input int clr_edge);
        int   ps;
        int   idx;
        logic rxv;
        ps = inst_b ? 16 : 8;
        for (int e = 0; e < ps; e++) begin
            @(negedge clk);
            idx = e + 2;
            rxv = bitval;
            if (idx < 16) begin
                if (low_mask[idx]) rxv = 1'b0;
            end
            if (inst_b) begin
                ec_b = 4'(e); rx_b = rxv; se_b = en_mask[e]; de_b = de; dc_b = (e == clr_edge);
            end else begin
                ec_a = 4'(e); rx_a = rxv; se_a = en_mask[e]; de_a = de; dc_a = (e == clr_edge);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ec_a = 4'd0; rx_a = 1'b1; se_a = 1'b0; de_a = 1'b0; dc_a = 1'b0;
            ec_b = 4'd0; rx_b = 1'b1; se_b = 1'b0; de_b = 1'b0; dc_b = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] byte_v;
        rst_a = 1'b1; rst_b = 1'b1;
        ec_a = 4'd0; rx_a = 1'b1; se_a = 1'b0; de_a = 1'b0; dc_a = 1'b0;
        ec_b = 4'd0; rx_b = 1'b1; se_b = 1'b0; de_b = 1'b0; dc_b = 1'b0;
        fork
            monitor_loop();
        join_none
        #1;
        check("reset_rx_sync", 32'(sync_a), 32'd1);
        check("reset_sampled_bit", 32'(sb_a), 32'd1);
        check("reset_sample_valid", 32'(sv_a), 32'd0);
        check("reset_p_data", 32'(pd_a), 32'd0);
        check("reset_byte_done", 32'(bd_a), 32'd0);
        check("reset_p_data_b", 32'(pd_b), 32'd0);
        idle(3);
        rst_a = 1'b0; rst_b = 1'b0;
        idle(4);

        // Clean frame 0xA5: start bit (clear count), 8 data bits, stop bit
        exp_bit_a.push_back(1'b0);
        send_bit(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 0);
        byte_v = 8'hA5;
        exp_byte_a.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            exp_bit_a.push_back(byte_v[i]);
            send_bit(1'b0, byte_v[i], 16'hFFFF, 16'h0000, 1'b1, -1);
        end
        exp_bit_a.push_back(1'b1);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, -1);
        check("gate_stop_p_data", 32'(pd_a), 32'hA5);

        // Glitch rejection: one low sample is outvoted, two low samples win
        exp_bit_a.push_back(1'b1);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0010, 1'b0, -1);
        exp_bit_a.push_back(1'b0);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0018, 1'b0, -1);
        check("gate_glitch_p_data", 32'(pd_a), 32'hA5);

        // No strobe: sample_en low all bit, then sample_en dropped at edge 4
        send_bit(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, -1);
        send_bit(1'b0, 1'b1, 16'hFFEF, 16'h0000, 1'b1, -1);
        check("no_strobe_hold_bit", 32'(sb_a), 32'd0);
        check("no_strobe_hold_p_data", 32'(pd_a), 32'hA5);

        // Clear priority: 3 shifts (1,1,0) then clear coincident with the strobe
        exp_bit_a.push_back(1'b1);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, -1);
        exp_bit_a.push_back(1'b1);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, -1);
        exp_bit_a.push_back(1'b0);
        send_bit(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, -1);
        check("three_shifts_p_data", 32'(pd_a), 32'h74);
        exp_bit_a.push_back(1'b1);
        send_bit(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 6);
        check("clr_drops_shift", 32'(pd_a), 32'h74);
        byte_v = 8'h3C;
        exp_byte_a.push_back(8'h3C);
        for (int i = 0; i < 8; i++) begin
            exp_bit_a.push_back(byte_v[i]);
            send_bit(1'b0, byte_v[i], 16'hFFFF, 16'h0000, 1'b1, -1);
        end
        check("after_clr_p_data", 32'(pd_a), 32'h3C);

        // Reset mid-frame: one more shift of 0, then reset inside the next bit
        exp_bit_a.push_back(1'b0);
        send_bit(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, -1);
        check("pre_reset_p_data", 32'(pd_a), 32'h1E);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            ec_a = 4'(e); rx_a = 1'b0; se_a = 1'b1; de_a = 1'b1; dc_a = 1'b0;
        end
        check("pre_reset_rx_sync", 32'(sync_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("midrun_reset_rx_sync", 32'(sync_a), 32'd1);
        check("midrun_reset_sampled_bit", 32'(sb_a), 32'd1);
        check("midrun_reset_sample_valid", 32'(sv_a), 32'd0);
        check("midrun_reset_p_data", 32'(pd_a), 32'd0);
        check("midrun_reset_byte_done", 32'(bd_a), 32'd0);
        idle(3);
        rst_a = 1'b0;
        idle(4);

        // PRESCALE=16 frame 0x5A
        exp_bit_b.push_back(1'b0);
        send_bit(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 0);
        byte_v = 8'h5A;
        exp_byte_b.push_back(8'h5A);
        for (int i = 0; i < 8; i++) begin
            exp_bit_b.push_back(byte_v[i]);
            send_bit(1'b1, byte_v[i], 16'hFFFF, 16'h0000, 1'b1, -1);
        end
        exp_bit_b.push_back(1'b1);
        send_bit(1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, -1);
        check("frame_b_p_data", 32'(pd_b), 32'h5A);
        idle(6);

        check("bitq_a_drained", 32'(exp_bit_a.size()), 32'd0);
        check("byteq_a_drained", 32'(exp_byte_a.size()), 32'd0);
        check("bitq_b_drained", 32'(exp_bit_b.size()), 32'd0);
        check("byteq_b_drained", 32'(exp_byte_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
